// File: rtl/dphy_clk_pkg.sv
// rtl/dphy_clk_pkg.sv - shared D-PHY clock-lane types and constants
package dphy_clk_pkg;

  typedef enum logic [3:0] {
    RX_STOP,
    HS_RQST,
    BRIDGE,
    SETTLE,
    HS_CLK,
    ULPS_RQST,
    ULPS,
    ULPS_EXIT,
    ERR_WAIT
  } clk_rx_state_t;

  // Line states as {lp_dp, lp_dn}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP10 = 2'b10;

  localparam int DEF_TERM_EN_CYC = 4;
  localparam int DEF_SETTLE_CYC  = 20;
  localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/lp_timer.sv
// rtl/lp_timer.sv - down-counter with load/clear, done when count is zero
module lp_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Saturates at zero: decrement requests are dropped once done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/hs_clk_rx_ctrl.sv
// rtl/hs_clk_rx_ctrl.sv - D-PHY clock-lane receive controller (LP decode, HS entry/exit, ULPS)
module hs_clk_rx_ctrl
  import dphy_clk_pkg::*;
#(
  parameter int TERM_EN_CYC = DEF_TERM_EN_CYC,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_enable,
  input  logic lp_dp,
  input  logic lp_dn,
  output logic term_en,
  output logic hs_rx_en,
  output logic clk_active,
  output logic stop_state,
  output logic ulps_active,
  output logic err_ctrl
);

  localparam logic [CNT_W-1:0] TERM_LOAD   = CNT_W'(TERM_EN_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  clk_rx_state_t    state;
  clk_rx_state_t    nxt;
  logic [1:0]       line;
  logic             t_load;
  logic             t_dec;
  logic             t_done;
  logic [CNT_W-1:0] t_val;

  assign line = {lp_dp, lp_dn};

  always_comb begin
    nxt    = state;
    t_load = 1'b0;
    t_val  = '0;
    if (!rx_enable) begin
      nxt = RX_STOP;
    end else begin
      case (state)
        RX_STOP: begin
          case (line)
            LP01:    nxt = HS_RQST;
            LP10:    nxt = ULPS_RQST;
            LP00:    nxt = ERR_WAIT;
            default: nxt = RX_STOP;
          endcase
        end
        HS_RQST: begin
          case (line)
            LP00: begin
              nxt    = BRIDGE;
              t_load = 1'b1;
              t_val  = TERM_LOAD;
            end
            LP11:    nxt = RX_STOP;
            LP10:    nxt = ERR_WAIT;
            default: nxt = HS_RQST;
          endcase
        end
        BRIDGE: begin
          case (line)
            LP00: begin
              if (t_done) begin
                nxt    = SETTLE;
                t_load = 1'b1;
                t_val  = SETTLE_LOAD;
              end
            end
            LP11:    nxt = RX_STOP;
            default: nxt = ERR_WAIT;
          endcase
        end
        // Line swings here are HS activity, not LP signalling; only LP-11 counts.
        SETTLE: begin
          if (line == LP11)  nxt = RX_STOP;
          else if (t_done)   nxt = HS_CLK;
        end
        HS_CLK: begin
          if (line == LP11) nxt = RX_STOP;
        end
        ULPS_RQST: begin
          case (line)
            LP00:    nxt = ULPS;
            LP11:    nxt = RX_STOP;
            LP01:    nxt = ERR_WAIT;
            default: nxt = ULPS_RQST;
          endcase
        end
        ULPS: begin
          if (line == LP10) nxt = ULPS_EXIT;
        end
        ULPS_EXIT: begin
          case (line)
            LP11:    nxt = RX_STOP;
            LP00:    nxt = ULPS;
            LP01:    nxt = ERR_WAIT;
            default: nxt = ULPS_EXIT;
          endcase
        end
        ERR_WAIT: begin
          if (line == LP11) nxt = RX_STOP;
        end
        default: nxt = RX_STOP;
      endcase
    end
  end

  assign t_dec = rx_enable && !t_load && (nxt == state) &&
                 ((state == BRIDGE) || (state == SETTLE));

  lp_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .clear    (!rx_enable),
    .dec      (t_dec),
    .load_val (t_val),
    .done     (t_done)
  );

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RX_STOP;
      term_en     <= 1'b0;
      hs_rx_en    <= 1'b0;
      clk_active  <= 1'b0;
      stop_state  <= 1'b1;
      ulps_active <= 1'b0;
      err_ctrl    <= 1'b0;
    end else begin
      state       <= nxt;
      term_en     <= (nxt == SETTLE) || (nxt == HS_CLK);
      hs_rx_en    <= (nxt == HS_CLK);
      clk_active  <= (nxt == HS_CLK);
      stop_state  <= (nxt == RX_STOP);
      ulps_active <= (nxt == ULPS) || (nxt == ULPS_EXIT);
      err_ctrl    <= (nxt == ERR_WAIT) && (state != ERR_WAIT);
    end
  end

endmodule

// File: tb/tb_hs_clk_rx_ctrl.sv
// tb/tb_hs_clk_rx_ctrl.sv - directed self-checking bench for hs_clk_rx_ctrl
module tb_hs_clk_rx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_enable = 1'b1;
  logic lp_dp = 1'b1;
  logic lp_dn = 1'b1;
  logic term_en, hs_rx_en, clk_active, stop_state, ulps_active, err_ctrl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hs_clk_rx_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rx_enable   (rx_enable),
    .lp_dp       (lp_dp),
    .lp_dn       (lp_dn),
    .term_en     (term_en),
    .hs_rx_en    (hs_rx_en),
    .clk_active  (clk_active),
    .stop_state  (stop_state),
    .ulps_active (ulps_active),
    .err_ctrl    (err_ctrl)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic te, input logic hr,
                           input logic ca, input logic ss, input logic ua,
                           input logic ec);
    check({tag, ".term_en"}, term_en, te);
    check({tag, ".hs_rx_en"}, hs_rx_en, hr);
    check({tag, ".clk_active"}, clk_active, ca);
    check({tag, ".stop_state"}, stop_state, ss);
    check({tag, ".ulps_active"}, ulps_active, ua);
    check({tag, ".err_ctrl"}, err_ctrl, ec);
  endtask

  // Drive a line value at the falling edge, sample just after the next rising edge.
  task automatic step(input logic [1:0] v);
    @(negedge clk);
    {lp_dp, lp_dn} = v;
    @(posedge clk);
    #1;
  endtask

  // From RX_STOP: 01 then 00 (enter BRIDGE), then 24 more 00 samples reach HS_CLK.
  task automatic burst_to_hs(input string tag);
    step(2'b01);
    step(2'b00);
    for (int i = 0; i < 24; i++) step(2'b00);
    check_all(tag, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    {lp_dp, lp_dn} = 2'b11;
    repeat (5) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step(2'b11);
    check_all("idle11", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Normal burst
    for (int i = 0; i < 3; i++) step(2'b01);
    check("rqst.stop", stop_state, 1'b0);
    step(2'b00);
    check("bridge0.term_en", term_en, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step(2'b00);
      check("bridge.term_en", term_en, 1'b0);
    end
    step(2'b00);
    check("settle.term_en", term_en, 1'b1);
    check("settle.clk_active", clk_active, 1'b0);
    for (int i = 1; i < 20; i++) begin
      step(2'b00);
      check("settle.clk_active_low", clk_active, 1'b0);
      check("settle.err", err_ctrl, 1'b0);
    end
    step(2'b00);
    check_all("hs_clk", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b01);
    check("hs_swing.clk_active", clk_active, 1'b1);
    step(2'b11);
    check_all("burst_exit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Abort from HS_RQST
    step(2'b01);
    check("abort.term_en0", term_en, 1'b0);
    step(2'b01);
    check("abort.term_en1", term_en, 1'b0);
    step(2'b11);
    check_all("abort", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Illegal 01 -> 10
    step(2'b01);
    step(2'b10);
    check_all("illegal", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step((i % 2 == 0) ? 2'b00 : 2'b01);
      check("err_wait.stop", stop_state, 1'b0);
      check("err_wait.err", err_ctrl, 1'b0);
    end
    step(2'b11);
    check("err_exit.stop", stop_state, 1'b1);

    // ULPS
    step(2'b10);
    check("ulps_rqst0.ulps", ulps_active, 1'b0);
    step(2'b10);
    check("ulps_rqst1.ulps", ulps_active, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(2'b00);
      check("ulps.ulps_active", ulps_active, 1'b1);
      check("ulps.term_en", term_en, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(2'b10);
      check("ulps_exit.ulps_active", ulps_active, 1'b1);
      check("ulps_exit.stop", stop_state, 1'b0);
    end
    step(2'b11);
    check_all("ulps_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // rx_enable dropped in HS_CLK
    burst_to_hs("hs_clk2");
    @(negedge clk);
    rx_enable = 1'b0;
    {lp_dp, lp_dn} = 2'b00;
    @(posedge clk);
    #1;
    check_all("disable", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2'b00);
    check_all("disabled00", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2'b01);
    check("disabled01.stop", stop_state, 1'b1);
    @(negedge clk);
    rx_enable = 1'b1;
    step(2'b11);
    check("reenable.stop", stop_state, 1'b1);
    burst_to_hs("hs_clk3");
    step(2'b11);
    check("burst3_exit.stop", stop_state, 1'b1);

    // Reset during SETTLE
    step(2'b01);
    for (int i = 0; i < 5; i++) step(2'b00);
    check("pre_rst.term_en", term_en, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_settle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(2'b11);
    check_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
